// File: rtl/pe_accumulator.sv
// pe_accumulator: valid/ready dot-product group accumulator with a sticky overflow flag.
// Define PE_ACC_SAT_EN to clamp acc_out at its maximum on overflow instead of wrapping.
module pe_accumulator #(
    parameter int ACC_W = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       product,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           state, state_nxt;
    logic             accept, first;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] acc_add;
    logic [CNT_W-1:0] cnt_inc;
    always_comb begin
        accept    = in_valid && in_ready;
        first     = state == IDLE;
        sum       = {1'b0, acc_out} + (ACC_W+1)'(product);
`ifdef PE_ACC_SAT_EN
        acc_add   = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
`else
        acc_add   = sum[ACC_W-1:0];
`endif
        cnt_inc   = &beat_cnt ? beat_cnt : beat_cnt + 1'b1;
        state_nxt = state == DONE ? (out_ready ? IDLE : DONE) :
                    accept ? (in_last ? DONE : ACCUM) : state;
    end
    // handshake flags are registered from the next state, so no input reaches them combinationally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc_out   <= '0;
            beat_cnt  <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= state_nxt != DONE;
            out_valid <= state_nxt == DONE;
            if (accept) begin
                acc_out  <= first ? ACC_W'(product) : acc_add;
                beat_cnt <= first ? CNT_W'(1) : cnt_inc;
                ovf      <= !first && (ovf || sum[ACC_W]);
            end
        end
    end
endmodule

// File: tb/tb_pe_accumulator.sv
// tb_pe_accumulator: checks a 16-bit and a 9-bit/3-bit-count instance side by side against a group-sum model.
module tb_pe_accumulator;
`ifdef PE_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    logic        clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic [7:0]  product = 0;
    logic        ir_a, ov_a, ovf_a, ir_b, ov_b, ovf_b;
    logic [15:0] acc_a;
    logic [7:0]  cnt_a;
    logic [8:0]  acc_b;
    logic [2:0]  cnt_b;
    int          checks = 0, failures = 0;
    int          grp[$];

    typedef struct {
        int n;
        int p[4];
        int gap;
        int stall;
        int acc_a;
        int cnt_a;
        int ovf_a;
        int acc_b;
        int ovf_b;
    } vec_t;
    vec_t tv[5];

    pe_accumulator dut_a (
        .clk(clk), .rst_n(rst_n), .product(product), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ir_a), .acc_out(acc_a), .beat_cnt(cnt_a), .ovf(ovf_a),
        .out_valid(ov_a), .out_ready(out_ready)
    );

    pe_accumulator #(.ACC_W(9), .CNT_W(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .product(product), .in_valid(in_valid), .in_last(in_last),
        .in_ready(ir_b), .acc_out(acc_b), .beat_cnt(cnt_b), .ovf(ovf_b),
        .out_valid(ov_b), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int model_acc(input int tot, input int w);
        int mx = (1 << w) - 1;
        return tot <= mx ? tot : SAT ? mx : tot % (mx + 1);
    endfunction

    task automatic send(input int p, input bit last);
        int k = 0;
        bit r;
        in_valid = 1;
        product  = 8'(p);
        in_last  = last;
        do begin
            r = ir_a;
            @(negedge clk);
            k++;
        end while (!r && k < 100);
        if (!r) check("accept_timeout", 0, 1);
        in_valid = 0;
        product  = 8'($urandom);
        in_last  = 1'($urandom);
    endtask

    task automatic run_group(input int gap, input int stall, input bit poke);
        int tot = 0, n = grp.size(), g, ea, eb, ca, cb;
        foreach (grp[i]) tot += grp[i];
        for (int i = 0; i < n; i++) begin
            send(grp[i], i == n - 1);
            if (i < n - 1) begin
                check("ov_mid", int'(ov_a), 0);
                g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
                repeat (g) @(negedge clk);
            end
        end
        ea = model_acc(tot, 16);
        eb = model_acc(tot, 9);
        ca = n > 255 ? 255 : n;
        cb = n > 7 ? 7 : n;
        check("done_valid_a", int'(ov_a), 1);
        check("done_valid_b", int'(ov_b), 1);
        check("done_ready", int'(ir_a), 0);
        check("acc_a", int'(acc_a), ea);
        check("acc_b", int'(acc_b), eb);
        check("cnt_a", int'(cnt_a), ca);
        check("cnt_b", int'(cnt_b), cb);
        check("ovf_a", int'(ovf_a), int'(tot > 65535));
        check("ovf_b", int'(ovf_b), int'(tot > 511));
        in_valid = poke;
        product  = 8'h55;
        in_last  = 0;
        repeat (stall) begin
            @(negedge clk);
            check("hold_valid", int'(ov_a), 1);
            check("hold_acc", int'(acc_a), ea);
            check("hold_cnt", int'(cnt_a), ca);
            check("hold_ready", int'(ir_a), 0);
        end
        in_valid  = 0;
        out_ready = 1;
        @(negedge clk);
        out_ready = 0;
        check("release_valid_a", int'(ov_a), 0);
        check("release_valid_b", int'(ov_b), 0);
        check("release_ready", int'(ir_a), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tv[0] = '{1, '{42, 0, 0, 0}, 0, 0, 42, 1, 0, 42, 0};
        tv[1] = '{4, '{255, 255, 255, 255}, 0, 5, 1020, 4, 0, SAT ? 511 : 508, 1};
        tv[2] = '{2, '{3, 7, 0, 0}, 4, 0, 10, 2, 0, 10, 0};
        tv[3] = '{3, '{255, 255, 5, 0}, 0, 1, 515, 3, 0, SAT ? 511 : 3, 1};
        tv[4] = '{1, '{0, 0, 0, 0}, 2, 2, 0, 1, 0, 0, 0};

        #1;
        check("rst_acc_a", int'(acc_a), 0);
        check("rst_cnt_a", int'(cnt_a), 0);
        check("rst_ovf_a", int'(ovf_a), 0);
        check("rst_valid_a", int'(ov_a), 0);
        check("rst_ready_a", int'(ir_a), 0);
        check("rst_ready_b", int'(ir_b), 0);
        repeat (3) @(negedge clk);
        check("rst_ready_held", int'(ir_a), 0);
        rst_n = 1;
        check("ready_pre_edge", int'(ir_a), 0);
        @(negedge clk);
        check("ready_post_edge", int'(ir_a), 1);

        for (int t = 0; t < 5; t++) begin
            grp.delete();
            for (int i = 0; i < tv[t].n; i++) grp.push_back(tv[t].p[i]);
            run_group(tv[t].gap, tv[t].stall, t == 1);
            check("tv_acc_a", int'(acc_a), tv[t].acc_a);
            check("tv_cnt_a", int'(cnt_a), tv[t].cnt_a);
            check("tv_ovf_a", int'(ovf_a), tv[t].ovf_a);
            check("tv_acc_b", int'(acc_b), tv[t].acc_b);
            check("tv_ovf_b", int'(ovf_b), tv[t].ovf_b);
        end

        send(5, 0);
        send(9, 0);
        rst_n = 0;
        #1;
        check("midrst_acc_a", int'(acc_a), 0);
        check("midrst_cnt_a", int'(cnt_a), 0);
        check("midrst_acc_b", int'(acc_b), 0);
        check("midrst_valid", int'(ov_a), 0);
        check("midrst_ready", int'(ir_a), 0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        grp.delete();
        grp.push_back(1);
        run_group(0, 0, 0);
        check("post_rst_acc", int'(acc_a), 1);
        check("post_rst_cnt", int'(cnt_a), 1);
        check("post_rst_ovf", int'(ovf_a), 0);

        grp.delete();
        repeat (300) grp.push_back(255);
        run_group(0, 1, 0);

        for (int g = 0; g < 25; g++) begin
            grp.delete();
            repeat ($urandom_range(1, 12)) grp.push_back(int'($urandom_range(0, 255)));
            run_group(-1, int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
